vga_sync_gen: RTL

VGA raster timing generator for the clock display. Counts pixel and line positions from the system clock, drives `hsync`/`vsync` to the monitor, and supplies `h_Disp`, `v_Disp`, `posX` and the linear pixel index `posY1` to the digit renderer. The renderer recovers the row as `posY1 / 640`, so the index is always `row * 640 + column`.

---
 rtl/vga_sync_gen.sv | 100 ++++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing with registered sync/blanking, column count and linear pixel index
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 2,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        hsync,
    output logic        vsync,
    output logic        h_Disp,
    output logic        v_Disp,
    output logic [10:0] posX,
    output logic [20:0] posY1,
    output logic        pix_en,
    output logic        frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [10:0] H_END_VIS  = 11'(H_VISIBLE - 1);
    localparam logic [10:0] H_END_FP   = 11'(H_VISIBLE + H_FP - 1);
    localparam logic [10:0] H_END_SYNC = 11'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [10:0] H_END      = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_END_VIS  = 11'(V_VISIBLE - 1);
    localparam logic [10:0] V_END_FP   = 11'(V_VISIBLE + V_FP - 1);
    localparam logic [10:0] V_END_SYNC = 11'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [10:0] V_END      = 11'(V_TOTAL - 1);
    localparam logic [20:0] ROW_STEP   = 21'(H_VISIBLE);
    localparam logic [1:0] ST_VIS  = 2'd0;
    localparam logic [1:0] ST_FP   = 2'd1;
    localparam logic [1:0] ST_SYNC = 2'd2;
    localparam logic [1:0] ST_BP   = 2'd3;

    logic [DW-1:0] div, div_n;
    logic [10:0]   h_cnt, h_n, v_cnt, v_n;
    logic [20:0]   row_base, rb_n;
    logic [1:0]    h_st, h_st_n, v_st, v_st_n;
    logic          line_end, frame_end;

    // Outputs are registered from the next-pixel values so they line up with the counters
    always_comb begin
        div_n     = div == DIV_LAST ? '0 : div + DW'(1);
        line_end  = h_cnt == H_END;
        frame_end = line_end && v_cnt == V_END;
        h_n       = line_end ? '0 : h_cnt + 11'd1;
        v_n       = !line_end ? v_cnt : v_cnt == V_END ? '0 : v_cnt + 11'd1;
        rb_n      = !line_end ? row_base : v_cnt == V_END ? '0 :
                    v_cnt < V_END_VIS ? row_base + ROW_STEP : row_base;
        h_st_n    = h_cnt == H_END_VIS ? ST_FP : h_cnt == H_END_FP ? ST_SYNC :
                    h_cnt == H_END_SYNC ? ST_BP : line_end ? ST_VIS : h_st;
        v_st_n    = !line_end ? v_st : v_cnt == V_END_VIS ? ST_FP : v_cnt == V_END_FP ? ST_SYNC :
                    v_cnt == V_END_SYNC ? ST_BP : v_cnt == V_END ? ST_VIS : v_st;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div         <= '0;
            pix_en      <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            row_base    <= '0;
            h_st        <= ST_VIS;
            v_st        <= ST_VIS;
            h_Disp      <= 1'b1;
            v_Disp      <= 1'b1;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            posY1       <= '0;
            frame_start <= 1'b0;
        end else begin
            div         <= div_n;
            pix_en      <= div_n == DIV_LAST;
            frame_start <= 1'b0;
            if (pix_en) begin
                h_cnt       <= h_n;
                v_cnt       <= v_n;
                row_base    <= rb_n;
                h_st        <= h_st_n;
                v_st        <= v_st_n;
                h_Disp      <= h_st_n == ST_VIS;
                v_Disp      <= v_st_n == ST_VIS;
                hsync       <= h_st_n == ST_SYNC ? SYNC_POL : ~SYNC_POL;
                vsync       <= v_st_n == ST_SYNC ? SYNC_POL : ~SYNC_POL;
                posY1       <= h_st_n == ST_VIS ? rb_n + 21'(h_n) : rb_n;
                frame_start <= frame_end;
            end
        end
    end

    assign posX = h_cnt;
endmodule
